// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_WAKE = 2'd1,
    CG_ON   = 2'd2,
    CG_IDLE = 2'd3
  } cg_state_e;

  // Counter width large enough to hold the longer of the wake and idle reload values.
  function automatic int unsigned cg_cnt_w(input int unsigned wake_cyc,
                                           input int unsigned idle_cyc);
    int unsigned m;
    m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: negedge-retimed enable ANDed with the source clock.
// Define CLK_GATE_TARGET_LIB to bind the library clock-AND cell; the behavioural AND is sim-only.
module clk_gate_cell (
  input  logic clk_in,
  input  logic rst,
  input  logic gate_en,
  output logic clk_out
);

  logic en_lat;

  // Enable only changes while clk_in is low, so the AND output can never produce a runt pulse.
  always_ff @(negedge clk_in) begin
    if (rst) begin
      en_lat <= 1'b0;
    end else begin
      en_lat <= gate_en;
    end
  end

`ifdef CLK_GATE_TARGET_LIB
  CKAND2 u_ckand (
    .A (en_lat),
    .B (clk_in),
    .Z (clk_out)
  );
`elsif SYNTHESIS
  $error("clk_gate_cell: define CLK_GATE_TARGET_LIB to bind a library clock-AND cell");
`else
  assign clk_out = en_lat & clk_in;
`endif

endmodule

// File: rtl/clk_gate_ctrl_mc.sv
// Multi-channel clock-gating controller: per-channel wake/idle FSM driving a glitch-free gate.
// Define CLK_GATE_STATS_EN to add per-channel gated-cycle counters (gated_cnt, stats_clr).
module clk_gate_ctrl_mc
  import clk_gate_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    busy,
  input  logic                 force_on,
`ifdef CLK_GATE_STATS_EN
  input  logic                 stats_clr,
  output logic [NUM_CH*32-1:0] gated_cnt,
`endif
  output logic [NUM_CH-1:0]    ack,
  output logic [NUM_CH-1:0]    gate_en,
  output logic [NUM_CH-1:0]    clk_out,
  output logic                 all_idle
);

  localparam int unsigned CNT_W = cg_cnt_w(WAKE_CYC, IDLE_CYC);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("clk_gate_ctrl_mc: NUM_CH must be in 1..32");
  end

  logic [NUM_CH-1:0] ch_off;

  assign all_idle = (&ch_off) & ~force_on;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_en_q, gate_en_d;
    logic             ack_q, ack_d;
    logic             active;

    assign active = req[i] | busy[i];

    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_q   <= CG_OFF;
        cnt_q     <= '0;
        gate_en_q <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        gate_en_q <= gate_en_d;
        ack_q     <= ack_d;
      end
    end

    // force_on freezes state and counter; only the registered outputs are overridden.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!force_on) begin
        unique case (state_q)
          CG_OFF: begin
            if (req[i]) begin
              state_d = CG_WAKE;
              cnt_d   = WAKE_LOAD;
            end
          end
          CG_WAKE: begin
            if (cnt_q == '0) begin
              state_d = CG_ON;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          CG_ON: begin
            if (!active) begin
              state_d = CG_IDLE;
              cnt_d   = IDLE_LOAD;
            end
          end
          CG_IDLE: begin
            if (active) begin
              state_d = CG_ON;
            end else if (cnt_q == '0) begin
              state_d = CG_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: state_d = CG_OFF;
        endcase
      end
    end

    always_comb begin
      gate_en_d = force_on | (state_q != CG_OFF);
      ack_d     = force_on | (state_q == CG_ON) | (state_q == CG_IDLE);
    end

    assign gate_en[i] = gate_en_q;
    assign ack[i]     = ack_q;
    assign ch_off[i]  = (state_q == CG_OFF);

    clk_gate_cell u_cell (
      .clk_in  (clk_in),
      .rst     (rst),
      .gate_en (gate_en_q),
      .clk_out (clk_out[i])
    );

`ifdef CLK_GATE_STATS_EN
    logic [31:0] gcnt_q;

    always_ff @(posedge clk_in) begin
      if (rst || stats_clr) begin
        gcnt_q <= '0;
      end else if (!gate_en_q && (gcnt_q != 32'hFFFF_FFFF)) begin
        gcnt_q <= gcnt_q + 32'd1;
      end
    end

    assign gated_cnt[i*32 +: 32] = gcnt_q;
`endif
  end

endmodule

// File: tb/tb_clk_gate_ctrl_mc.sv
// Self-checking bench for clk_gate_ctrl_mc: directed table, corner sequences, random vs model.
module tb_clk_gate_ctrl_mc;

  localparam int NUM_CH   = 4;
  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 16;

  localparam int M_OFF  = 0;
  localparam int M_WAKE = 1;
  localparam int M_RUN  = 2;

  logic              clk_in   = 1'b0;
  logic              rst      = 1'b1;
  logic              force_on = 1'b0;
  logic [NUM_CH-1:0] req      = '0;
  logic [NUM_CH-1:0] busy     = '0;
  logic [NUM_CH-1:0] ack, gate_en, clk_out;
  logic              all_idle;
`ifdef CLK_GATE_STATS_EN
  logic                 stats_clr = 1'b0;
  logic [NUM_CH*32-1:0] gated_cnt;
  int unsigned          m_gcnt[NUM_CH];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a channel is off, waking (age = cycles since request) or running
  // (age = consecutive idle samples); outputs are the previous edge's view plus force_on.
  int                m_mode[NUM_CH];
  int                m_age[NUM_CH];
  logic [NUM_CH-1:0] exp_gate = '0;
  logic [NUM_CH-1:0] exp_ack  = '0;
  logic [NUM_CH-1:0] exp_clk  = '0;
  logic              exp_all_idle = 1'b1;

  typedef struct {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] busy;
    logic              force_on;
    logic [NUM_CH-1:0] exp_gate;
    logic [NUM_CH-1:0] exp_ack;
    logic              exp_all_idle;
  } vec_t;

  vec_t tbl[7];

  clk_gate_ctrl_mc #(
    .NUM_CH   (NUM_CH),
    .WAKE_CYC (WAKE_CYC),
    .IDLE_CYC (IDLE_CYC)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req       (req),
    .busy      (busy),
    .force_on  (force_on),
`ifdef CLK_GATE_STATS_EN
    .stats_clr (stats_clr),
    .gated_cnt (gated_cnt),
`endif
    .ack       (ack),
    .gate_en   (gate_en),
    .clk_out   (clk_out),
    .all_idle  (all_idle)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] was_off, was_run;
    exp_clk = exp_gate;
    for (int i = 0; i < NUM_CH; i++) begin
      was_off[i] = (m_mode[i] == M_OFF);
      was_run[i] = (m_mode[i] == M_RUN);
    end
`ifdef CLK_GATE_STATS_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || stats_clr) m_gcnt[i] = 0;
      else if (!exp_gate[i] && m_gcnt[i] != 32'hFFFF_FFFF) m_gcnt[i] = m_gcnt[i] + 1;
    end
`endif
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = M_OFF;
        m_age[i]  = 0;
      end
      exp_gate = '0;
      exp_ack  = '0;
    end else begin
      exp_gate = force_on ? '1 : ~was_off;
      exp_ack  = force_on ? '1 : was_run;
      if (!force_on) begin
        for (int i = 0; i < NUM_CH; i++) begin
          case (m_mode[i])
            M_OFF: if (req[i]) begin
              m_mode[i] = M_WAKE;
              m_age[i]  = 0;
            end
            M_WAKE: begin
              m_age[i]++;
              if (m_age[i] == WAKE_CYC) begin
                m_mode[i] = M_RUN;
                m_age[i]  = 0;
              end
            end
            default: begin
              if (req[i] | busy[i]) m_age[i] = 0;
              else m_age[i]++;
              if (m_age[i] == IDLE_CYC + 1) begin
                m_mode[i] = M_OFF;
                m_age[i]  = 0;
              end
            end
          endcase
        end
      end
    end
    exp_all_idle = !force_on;
    for (int i = 0; i < NUM_CH; i++) if (m_mode[i] != M_OFF) exp_all_idle = 1'b0;
  endtask

  // One clock: model update at the edge, outputs sampled in the high and low phases.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #2;
    chk("gate_en", 64'(gate_en), 64'(exp_gate));
    chk("ack", 64'(ack), 64'(exp_ack));
    chk("all_idle", 64'(all_idle), 64'(exp_all_idle));
    chk("clk_out_high_phase", 64'(clk_out), 64'(exp_clk));
`ifdef CLK_GATE_STATS_EN
    for (int i = 0; i < NUM_CH; i++) chk("gated_cnt", 64'(gated_cnt[i*32 +: 32]), 64'(m_gcnt[i]));
`endif
    #5;
    chk("clk_out_low_phase", 64'(clk_out), 64'd0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    busy     = '0;
    force_on = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = M_OFF;
      m_age[i]  = 0;
`ifdef CLK_GATE_STATS_EN
      m_gcnt[i] = 0;
`endif
    end
    // Wake with a req drop mid-WAKE, then force_on freezing an ON channel.
    tbl[0] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[3] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0};
    tbl[4] = '{4'b0001, 4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b0};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b1111, 1'b0};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0};

    // Settle the negedge enable flops before the first checked cycle.
    @(posedge clk_in);
    #7;
    step();
    rst = 1'b0;
    chk("reset_all_idle", 64'(all_idle), 64'd1);
    chk("reset_gate_en", 64'(gate_en), 64'd0);

    for (int k = 0; k < 7; k++) begin
      req      = tbl[k].req;
      busy     = tbl[k].busy;
      force_on = tbl[k].force_on;
      step();
      chk("tbl_gate_en", 64'(gate_en), 64'(tbl[k].exp_gate));
      chk("tbl_ack", 64'(ack), 64'(tbl[k].exp_ack));
      chk("tbl_all_idle", 64'(all_idle), 64'(tbl[k].exp_all_idle));
    end

    // Idle timeout, then a busy pulse that restarts the timeout.
    do_reset();
    req[0] = 1'b1;
    run(4);
    req[0] = 1'b0;
    run(IDLE_CYC + 1);
    chk("idle_gate_still_open", 64'(gate_en[0]), 64'd1);
    run(1);
    chk("idle_gate_closed", 64'(gate_en[0]), 64'd0);
    chk("idle_ack_dropped", 64'(ack[0]), 64'd0);
    req[0] = 1'b1;
    run(4);
    req[0] = 1'b0;
    run(10);
    busy[0] = 1'b1;
    run(1);
    busy[0] = 1'b0;
    run(IDLE_CYC + 1);
    chk("busy_restart_gate_open", 64'(gate_en[0]), 64'd1);
    run(1);
    chk("busy_restart_gate_closed", 64'(gate_en[0]), 64'd0);

    // Busy arriving on the same edge the idle counter expires keeps the channel on.
    do_reset();
    req[1] = 1'b1;
    run(4);
    req[1] = 1'b0;
    for (int k = 0; k < IDLE_CYC; k++) begin
      run(1);
      chk("race_ack_held", 64'(ack[1]), 64'd1);
    end
    busy[1] = 1'b1;
    run(1);
    busy[1] = 1'b0;
    chk("race_ack_after", 64'(ack[1]), 64'd1);
    run(IDLE_CYC + 1);
    chk("race_gate_held", 64'(gate_en[1]), 64'd1);

    // force_on with every channel off.
    do_reset();
    force_on = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run(1);
      chk("force_gate_en", 64'(gate_en), 64'hF);
      chk("force_ack", 64'(ack), 64'hF);
      chk("force_all_idle", 64'(all_idle), 64'd0);
    end
    force_on = 1'b0;
    run(1);
    chk("force_release_gate_en", 64'(gate_en), 64'd0);
    chk("force_release_ack", 64'(ack), 64'd0);
    chk("force_release_all_idle", 64'(all_idle), 64'd1);

    // Reset during WAKE, then restart with req held.
    do_reset();
    req[2] = 1'b1;
    run(1);
    rst = 1'b1;
    run(1);
    chk("wake_reset_gate", 64'(gate_en[2]), 64'd0);
    chk("wake_reset_ack", 64'(ack[2]), 64'd0);
    rst = 1'b0;
    run(2);
    chk("wake_restart_gate", 64'(gate_en[2]), 64'd1);
    run(2);
    chk("wake_restart_ack", 64'(ack[2]), 64'd1);

`ifdef CLK_GATE_STATS_EN
    do_reset();
    run(49);
    stats_clr = 1'b1;
    run(1);
    stats_clr = 1'b0;
    run(50);
    chk("stats_ch3_after_clear", 64'(gated_cnt[3*32 +: 32]), 64'd50);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
        busy[i] = ($urandom_range(0, 29) == 0);
      end
      force_on = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 299) == 0);
`ifdef CLK_GATE_STATS_EN
      stats_clr = ($urandom_range(0, 199) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
